// File: rtl/panel_load_sequencer_pkg.sv
// Shared types and default timing for the PDP-8 front-panel load sequencer.
// The cycle constants are the Front_Panel debounce-friendly defaults.
package panel_load_sequencer_pkg;

    typedef logic [11:0] pdp8_word_t;

    localparam int         DEF_SETUP_CYCLES  = 10;
    localparam int         DEF_PULSE_CYCLES  = 10;
    localparam int         DEF_SETTLE_CYCLES = 30;
    localparam pdp8_word_t DEF_START_PC      = 12'o0200;
    localparam int         WORDS_MAX         = 4096;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_WORD,
        ST_ADDR_SETUP,
        ST_LOAD_PULSE,
        ST_LOAD_GAP,
        ST_DATA_SETUP,
        ST_DEP_PULSE,
        ST_DEP_GAP,
        ST_RUN_SETUP,
        ST_RUNNING,
        ST_DONE
    } panel_seq_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/panel_load_sequencer_phase_timer.sv
// Shared phase down-counter: reloaded on start, expires when it reaches zero
// and then holds there until the next reload.
module panel_load_sequencer_phase_timer #(
    parameter int W = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start_i,
    input  logic [W-1:0] load_value_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (start_i) begin
            cnt_q <= load_value_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/panel_load_sequencer.sv
// Drives Front_Panel sw/btnl/btnd to deposit an (addr, data) image, loads the
// start PC, sets run and reports when the CPU halts again.
module panel_load_sequencer
    import panel_load_sequencer_pkg::*;
#(
    parameter int         SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int         PULSE_CYCLES  = DEF_PULSE_CYCLES,
    parameter int         SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter pdp8_word_t START_PC      = DEF_START_PC
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [11:0]      in_addr,
    input  logic [11:0]      in_data,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             run_led,
    output logic [12:0]      sw,
    output logic             load_pc_btn,
    output logic             deposit_btn,
    output logic             busy,
    output logic             done,
    output logic [12:0]      words_loaded,
    output panel_seq_state_t dbg_state_o,
    output logic [11:0]      dbg_next_pc_o
);

    localparam int CNT_W = $clog2(max3(SETUP_CYCLES, PULSE_CYCLES, SETTLE_CYCLES)) + 1;

    // Word handshake: a word moves on a rising edge where in_valid and
    // in_ready are both high; in_ready is only ever high in WAIT_WORD.
    panel_seq_state_t state_q, state_d;
    pdp8_word_t       sw_val_q, sw_val_d;
    logic             run_sw_q, run_sw_d;
    logic             load_btn_q, load_btn_d;
    logic             dep_btn_q, dep_btn_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [12:0]      words_q, words_d;
    pdp8_word_t       addr_q, addr_d;
    pdp8_word_t       data_q, data_d;
    logic             last_q, last_d;
    pdp8_word_t       next_pc_q, next_pc_d;
    logic             first_q, first_d;
    logic             final_q, final_d;

    logic             xfer;
    logic             timer_start;
    logic [CNT_W-1:0] timer_load;
    logic             expired;

    panel_load_sequencer_phase_timer #(.W(CNT_W)) u_timer (
        .clock        (clock),
        .reset        (reset),
        .start_i      (timer_start),
        .load_value_i (timer_load),
        .expired_o    (expired)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sw_val_q   <= '0;
            run_sw_q   <= 1'b0;
            load_btn_q <= 1'b0;
            dep_btn_q  <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            words_q    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            next_pc_q  <= '0;
            first_q    <= 1'b1;
            final_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sw_val_q   <= sw_val_d;
            run_sw_q   <= run_sw_d;
            load_btn_q <= load_btn_d;
            dep_btn_q  <= dep_btn_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            words_q    <= words_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            last_q     <= last_d;
            next_pc_q  <= next_pc_d;
            first_q    <= first_d;
            final_q    <= final_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sw_val_d   = sw_val_q;
        run_sw_d   = run_sw_q;
        load_btn_d = 1'b0;
        dep_btn_d  = 1'b0;
        in_ready_d = 1'b0;
        done_d     = done_q;
        words_d    = words_q;
        addr_d     = addr_q;
        data_d     = data_q;
        last_d     = last_q;
        next_pc_d  = next_pc_q;
        first_d    = first_q;
        final_d    = final_q;
        xfer       = in_valid && in_ready_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_WAIT_WORD;
                    words_d = '0;
                    done_d  = 1'b0;
                    first_d = 1'b1;
                    final_d = 1'b0;
                end
            end
            ST_WAIT_WORD: begin
                in_ready_d = 1'b1;
                if (xfer) begin
                    in_ready_d = 1'b0;
                    addr_d     = in_addr;
                    data_d     = in_data;
                    last_d     = in_last;
                    // Deposit auto-increments the panel PC, so a contiguous
                    // word can skip the load-PC step.
                    if (!first_q && in_addr == next_pc_q) begin
                        state_d  = ST_DATA_SETUP;
                        sw_val_d = in_data;
                    end else begin
                        state_d  = ST_ADDR_SETUP;
                        sw_val_d = in_addr;
                    end
                end
            end
            ST_ADDR_SETUP: begin
                if (expired) begin
                    state_d    = ST_LOAD_PULSE;
                    load_btn_d = 1'b1;
                end
            end
            ST_LOAD_PULSE: begin
                load_btn_d = !expired;
                if (expired) begin
                    state_d = ST_LOAD_GAP;
                end
            end
            ST_LOAD_GAP: begin
                if (expired) begin
                    if (final_q) begin
                        state_d  = ST_RUN_SETUP;
                        run_sw_d = 1'b1;
                    end else begin
                        state_d  = ST_DATA_SETUP;
                        sw_val_d = data_q;
                    end
                end
            end
            ST_DATA_SETUP: begin
                if (expired) begin
                    state_d   = ST_DEP_PULSE;
                    dep_btn_d = 1'b1;
                end
            end
            ST_DEP_PULSE: begin
                dep_btn_d = !expired;
                if (expired) begin
                    state_d = ST_DEP_GAP;
                end
            end
            ST_DEP_GAP: begin
                if (expired) begin
                    if (words_q != 13'(WORDS_MAX)) begin
                        words_d = words_q + 13'd1;
                    end
                    next_pc_d = addr_q + 12'd1;
                    first_d   = 1'b0;
                    if (last_q) begin
                        final_d  = 1'b1;
                        addr_d   = START_PC;
                        sw_val_d = START_PC;
                        state_d  = ST_ADDR_SETUP;
                    end else begin
                        state_d = ST_WAIT_WORD;
                    end
                end
            end
            ST_RUN_SETUP: begin
                if (run_led) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (!run_led) begin
                    state_d  = ST_DONE;
                    run_sw_d = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d      = (state_d != ST_IDLE) && (state_d != ST_DONE);
        timer_start = (state_d != state_q);

        case (state_d)
            ST_ADDR_SETUP, ST_DATA_SETUP, ST_DEP_GAP: timer_load = CNT_W'(SETUP_CYCLES - 1);
            ST_LOAD_PULSE, ST_DEP_PULSE:              timer_load = CNT_W'(PULSE_CYCLES - 1);
            ST_LOAD_GAP:                              timer_load = CNT_W'(SETTLE_CYCLES - 1);
            default:                                  timer_load = '0;
        endcase
    end

    assign sw            = {run_sw_q, sw_val_q};
    assign load_pc_btn   = load_btn_q;
    assign deposit_btn   = dep_btn_q;
    assign in_ready      = in_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign words_loaded  = words_q;
    assign dbg_state_o   = state_q;
    assign dbg_next_pc_o = next_pc_q;

endmodule

// File: tb/tb_panel_load_sequencer.sv
// Self-checking bench for panel_load_sequencer: button events and handshake
// latencies are predicted from the image with a simple address-contiguity model.
module tb_panel_load_sequencer;
    import panel_load_sequencer_pkg::*;

    localparam int         S   = 10;
    localparam int         P   = 10;
    localparam int         T   = 30;
    localparam logic [11:0] SPC = 12'o0200;
    localparam int         LAT_LOAD = S + P + T + S + P + S + 1;
    localparam int         LAT_SEQ  = S + P + S + 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic             in_valid;
    logic [11:0]      in_addr;
    logic [11:0]      in_data;
    logic             in_last;
    logic             in_ready;
    logic             run_led;
    logic [12:0]      sw;
    logic             load_pc_btn;
    logic             deposit_btn;
    logic             busy;
    logic             done;
    logic [12:0]      words_loaded;
    panel_seq_state_t dbg_state;
    logic [11:0]      dbg_next_pc;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Observed events: {1=load / 0=deposit, sw value}
    logic [12:0] obs_q[$];
    int          obs_cyc_q[$];
    int          rdy_q[$];
    logic        prev_l = 1'b0;
    logic        prev_d = 1'b0;
    logic        prev_r = 1'b0;
    logic        both_hi_seen = 1'b0;

    logic [12:0] exp_q[$];
    int          exp_lat_q[$];
    int          xfer_q[$];
    logic [11:0] wa[$];
    logic [11:0] wd[$];
    int          obs_base;
    int          rdy_base;

    panel_load_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .in_valid      (in_valid),
        .in_addr       (in_addr),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .run_led       (run_led),
        .sw            (sw),
        .load_pc_btn   (load_pc_btn),
        .deposit_btn   (deposit_btn),
        .busy          (busy),
        .done          (done),
        .words_loaded  (words_loaded),
        .dbg_state_o   (dbg_state),
        .dbg_next_pc_o (dbg_next_pc)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (load_pc_btn && !prev_l) begin
            obs_q.push_back({1'b1, sw[11:0]});
            obs_cyc_q.push_back(cyc);
        end
        if (deposit_btn && !prev_d) begin
            obs_q.push_back({1'b0, sw[11:0]});
            obs_cyc_q.push_back(cyc);
        end
        if (in_ready && !prev_r) rdy_q.push_back(cyc);
        if (load_pc_btn && deposit_btn) both_hi_seen <= 1'b1;
        prev_l <= load_pc_btn;
        prev_d <= deposit_btn;
        prev_r <= in_ready;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic push_word(input logic [11:0] a, input logic [11:0] d, input logic l);
        int w;
        in_addr  = a;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 400) begin
            tick(1);
            w++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout addr=%o got in_ready=%b expected 1", a, in_ready);
            in_valid = 1'b0;
            return;
        end
        xfer_q.push_back(cyc + 1);
        tick(1);
        in_valid = 1'b0;
    endtask

    // Model: a load-PC precedes a deposit unless the address continues the
    // previous one (mod 4096); the image ends with a load of the start PC.
    task automatic build_expected;
        logic [11:0] prev;
        bit          first;
        bit          need;
        exp_q.delete();
        exp_lat_q.delete();
        first = 1;
        prev  = '0;
        for (int i = 0; i < wa.size(); i++) begin
            need = first || (wa[i] != prev + 12'd1);
            if (need) exp_q.push_back({1'b1, wa[i]});
            exp_q.push_back({1'b0, wd[i]});
            exp_lat_q.push_back(need ? LAT_LOAD : LAT_SEQ);
            prev  = wa[i];
            first = 0;
        end
        exp_q.push_back({1'b1, SPC});
    endtask

    task automatic run_image(input string name, input int gap_at, input int gap_len);
        int          n;
        int          w;
        bit          ok;
        logic [12:0] snap;
        logic [11:0] exp_pc;
        n = wa.size();
        build_expected();
        obs_base = obs_q.size();
        rdy_base = rdy_q.size();
        xfer_q.delete();
        pulse_start();
        for (int i = 0; i < n; i++) begin
            if (i == gap_at && gap_len > 0) begin
                w = 0;
                while (!in_ready && w < 400) begin
                    tick(1);
                    w++;
                end
                snap = sw;
                ok = 1;
                for (int k = 0; k < gap_len; k++) begin
                    tick(1);
                    if (in_ready !== 1'b1 || sw !== snap || load_pc_btn !== 1'b0 ||
                        deposit_btn !== 1'b0 || dbg_state !== ST_WAIT_WORD) ok = 0;
                end
                n_cmp++;
                if (!ok) begin
                    n_bad++;
                    $display("FAIL %s gap_hold: sw=%h in_ready=%b got unstable, expected sw=%h held with in_ready=1",
                             name, sw, in_ready, snap);
                end
            end
            push_word(wa[i], wd[i], (i == n - 1));
        end
        w = 0;
        while (sw[12] !== 1'b1 && w < 400) begin
            tick(1);
            w++;
        end
        n_cmp++;
        if (sw[12] !== 1'b1) begin
            n_bad++;
            $display("FAIL %s run_switch: got %b expected 1", name, sw[12]);
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s busy_running: got %b expected 1", name, busy);
        end
        n_cmp++;
        if (obs_q.size() - obs_base !== exp_q.size()) begin
            n_bad++;
            $display("FAIL %s event_count: got %0d expected %0d", name, obs_q.size() - obs_base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && obs_base + i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[obs_base + i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL %s event[%0d]: got kind=%b sw=%o expected kind=%b sw=%o", name, i,
                         obs_q[obs_base + i][12], obs_q[obs_base + i][11:0], exp_q[i][12], exp_q[i][11:0]);
            end
        end
        for (int i = 0; i + 1 < n && i < xfer_q.size() && rdy_base + i + 1 < rdy_q.size(); i++) begin
            n_cmp++;
            if (rdy_q[rdy_base + i + 1] - xfer_q[i] !== exp_lat_q[i]) begin
                n_bad++;
                $display("FAIL %s ready_latency[%0d]: got %0d expected %0d", name, i,
                         rdy_q[rdy_base + i + 1] - xfer_q[i], exp_lat_q[i]);
            end
        end
        n_cmp++;
        if (words_loaded !== 13'(n)) begin
            n_bad++;
            $display("FAIL %s words_loaded: got %0d expected %0d", name, words_loaded, n);
        end
        exp_pc = wa[n - 1] + 12'd1;
        n_cmp++;
        if (dbg_next_pc !== exp_pc) begin
            n_bad++;
            $display("FAIL %s next_pc: got %o expected %o", name, dbg_next_pc, exp_pc);
        end
        n_cmp++;
        if (both_hi_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL %s both_buttons: got %b expected 0", name, both_hi_seen);
        end
    endtask

    task automatic finish_run(input string name, input int hi);
        bit ok;
        ok = 1;
        run_led = 1'b1;
        for (int k = 0; k < hi; k++) begin
            tick(1);
            if (sw[12] !== 1'b1 || done !== 1'b0 || busy !== 1'b1) ok = 0;
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s run_hold: got sw12=%b done=%b expected sw12=1 done=0", name, sw[12], done);
        end
        run_led = 1'b0;
        tick(1);
        n_cmp++;
        if (sw[12] !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s halt: got sw12=%b done=%b busy=%b expected 0 1 0", name, sw[12], done, busy);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        in_last = 1'b0; run_led = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
        n_cmp++;
        if (sw !== 13'd0 || load_pc_btn !== 1'b0 || deposit_btn !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got sw=%h lb=%b db=%b rdy=%b expected all 0", sw, load_pc_btn, deposit_btn, in_ready);
        end
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || words_loaded !== 13'd0 || dbg_state !== ST_IDLE) begin
            n_bad++;
            $display("FAIL reset_status: got busy=%b done=%b words=%0d state=%0d expected 0 0 0 IDLE",
                     busy, done, words_loaded, dbg_state);
        end
    endtask

    task automatic test_single_word;
        wa = '{12'o0200};
        wd = '{12'o7402};
        run_image("single", -1, 0);
        n_cmp++;
        if (obs_cyc_q.size() <= obs_base || xfer_q.size() < 1 || obs_cyc_q[obs_base] - xfer_q[0] !== S) begin
            n_bad++;
            $display("FAIL single_load_delay: got %0d expected %0d",
                     (obs_cyc_q.size() > obs_base && xfer_q.size() > 0) ? obs_cyc_q[obs_base] - xfer_q[0] : -1, S);
        end
        finish_run("single", 5);
    endtask

    task automatic test_sequential;
        wa = '{12'o0200, 12'o0201, 12'o0202, 12'o0300};
        wd = '{12'o1111, 12'o2222, 12'o3333, 12'o4444};
        run_image("sequential", -1, 0);
        finish_run("sequential", 3);
    endtask

    task automatic test_wrap;
        wa = '{12'o7777, 12'o0000};
        wd = '{12'o0123, 12'o4567};
        run_image("wrap", -1, 0);
        finish_run("wrap", 2);
    endtask

    task automatic test_valid_gap;
        wa = '{12'o0400, 12'o0401, 12'o0402};
        wd = '{12'o7001, 12'o7002, 12'o7003};
        run_image("valid_gap", 2, 50);
        finish_run("valid_gap", 4);
    endtask

    task automatic test_run_done;
        wa = '{12'o0600};
        wd = '{12'o5252};
        run_image("run_done", -1, 0);
        finish_run("run_done", 100);
        tick(5);
        pulse_start();
        n_cmp++;
        if (done !== 1'b0 || words_loaded !== 13'd0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_clear: got done=%b words=%0d busy=%b expected 0 0 1", done, words_loaded, busy);
        end
    endtask

    task automatic test_reset_mid;
        int w;
        bit ok;
        push_word(12'o0500, 12'o1234, 1'b0);
        w = 0;
        while (deposit_btn !== 1'b1 && w < 300) begin
            tick(1);
            w++;
        end
        n_cmp++;
        if (deposit_btn !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_reach_pulse: got deposit_btn=%b expected 1", deposit_btn);
        end
        reset = 1'b1;
        tick(1);
        n_cmp++;
        if (deposit_btn !== 1'b0 || busy !== 1'b0 || dbg_state !== ST_IDLE || words_loaded !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_mid: got db=%b busy=%b state=%0d words=%0d expected 0 0 IDLE 0",
                     deposit_btn, busy, dbg_state, words_loaded);
        end
        reset = 1'b0;
        in_valid = 1'b1;
        ok = 1;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (in_ready !== 1'b0 || dbg_state !== ST_IDLE || words_loaded !== 13'd0) ok = 0;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL idle_ignores_valid: got rdy=%b state=%0d expected 0 IDLE", in_ready, dbg_state);
        end
    endtask

    task automatic test_random;
        int          n;
        logic [11:0] a;
        for (int s = 0; s < 6; s++) begin
            wa.delete();
            wd.delete();
            n = $urandom_range(2, 6);
            a = 12'($urandom_range(0, 4095));
            for (int i = 0; i < n; i++) begin
                if (i > 0) begin
                    if ($urandom_range(0, 9) < 7) a = a + 12'd1;
                    else a = 12'($urandom_range(0, 4095));
                end
                wa.push_back(a);
                wd.push_back(12'($urandom_range(0, 4095)));
            end
            run_image("random", $urandom_range(0, n - 1), $urandom_range(0, 20));
            finish_run("random", $urandom_range(1, 30));
            tick($urandom_range(0, 5));
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_sequential();
        test_wrap();
        test_valid_gap();
        test_run_done();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
